asynch_receiver: RTL and testbench

//  Serial-to-parallel UART receiver, 8N1, LSB first, line idle high.
//  It is the receiving end for frames generated by asynch_transmitter.
//  It sits between the rxd pin and the byte-consumer logic (FIFO, framer).
//  It oversamples rxd, validates the start and stop bits, and presents each good byte with a one-cycle rdy pulse.

---
 rtl/asynch_receiver.sv | 151 +++++++++++++++
 tb/tb_asynch_receiver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/asynch_receiver.sv
// 8N1 UART receiver: oversamples a synchronized rxd, checks start/stop bits and
// emits each good byte with a single-cycle rdy pulse (ferr on a bad stop bit).
module asynch_receiver #(
  parameter int CLKFREQ = 100_000_000,
  parameter int BAUD    = 9600,
  parameter int SAMPLE  = 16
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr,
  output logic       busy
);

  localparam int DIV    = CLKFREQ / (BAUD * SAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(SAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(SAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(SAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state;
  state_t state_next;

  logic              rxd_m;
  logic              rxd_s;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              rdy_set;
  logic              ferr_set;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Held in IDLE so the first tick lands DIV clocks after the start edge.
  always_ff @(posedge clk_100mhz) begin
    if (reset || state == IDLE) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rdy_set    = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) state_next = START;
      end
      START: begin
        if (tick && tick_cnt == HALF_LAST) state_next = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && tick_cnt == BIT_LAST && bit_cnt == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (tick && tick_cnt == BIT_LAST) begin
          if (rxd_s) begin
            rdy_set    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timing and shifting; data bits are taken one full bit after mid-start.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data     <= '0;
      rdy      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rdy  <= rdy_set;
      ferr <= ferr_set;
      if (rdy_set) data <= shreg;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        START: begin
          if (tick) tick_cnt <= (tick_cnt == HALF_LAST) ? '0 : tick_cnt + 1'b1;
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxd_s, shreg[7:1]};
              if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) tick_cnt <= (tick_cnt == BIT_LAST) ? '0 : tick_cnt + 1'b1;
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_asynch_receiver.sv
// Self-checking bench for asynch_receiver: the bench plays the transmitter and
// predicts received bytes with a queue of frames it sent with a good stop bit.
module tb_asynch_receiver;

  localparam int BIT_CLK = 160;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_count = 0;
  int ferr_count = 0;
  int sent_good = 0;
  int start_cyc = 0;
  logic prev_rdy = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  int rdy_cycs[$];

  asynch_receiver #(
    .CLKFREQ(100_000_000),
    .BAUD   (625_000),
    .SAMPLE (16)
  ) dut (
    .clk_100mhz(clk),
    .reset     (reset),
    .rxd       (rxd),
    .data      (data),
    .rdy       (rdy),
    .ferr      (ferr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmit one 8N1 frame LSB first; a good stop bit enters the expected queue.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input int bit_len);
    if (stop_val) begin
      exp_q.push_back(b);
      sent_good++;
    end
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (bit_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bit_len) @(negedge clk);
    end
    rxd = stop_val;
    repeat (bit_len) @(negedge clk);
  endtask

  // Watch the pulses: each rdy consumes the oldest predicted byte.
  always @(negedge clk) begin
    if (rdy || ferr) checkOutput("rdy_ferr_excl", 32'(rdy & ferr), 32'd0);
    if (rdy) begin
      rdy_count++;
      rdy_cycs.push_back(cyc);
      checkOutput("rdy_single", 32'(prev_rdy), 32'd0);
      checkOutput("rdy_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        last_good = exp_q.pop_front();
        checkOutput("rdy_data", 32'(data), 32'(last_good));
      end
    end
    if (ferr) begin
      ferr_count++;
      checkOutput("ferr_single", 32'(prev_ferr), 32'd0);
      checkOutput("ferr_data_held", 32'(data), 32'(last_good));
    end
    prev_rdy = rdy;
    prev_ferr = ferr;
  end

  initial begin
    int base_rdy;
    int base_ferr;
    int base_idx;
    int lat;
    logic [7:0] b;
    int len;
    int gap;

    reset = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'h00);
    checkOutput("reset_rdy", 32'(rdy), 32'd0);
    checkOutput("reset_ferr", 32'(ferr), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Single frame with latency to mid stop bit.
    base_rdy = rdy_count;
    base_ferr = ferr_count;
    base_idx = rdy_cycs.size();
    applyStimulus(8'hA5, 1'b1, BIT_CLK);
    checkOutput("t1_rdy_count", 32'(rdy_count - base_rdy), 32'd1);
    checkOutput("t1_data", 32'(data), 32'hA5);
    checkOutput("t1_ferr", 32'(ferr_count - base_ferr), 32'd0);
    if (rdy_cycs.size() > base_idx) begin
      lat = rdy_cycs[base_idx] - start_cyc;
      checkOutput("t1_latency_window", 32'(lat >= 1520 && lat <= 1526), 32'd1);
    end

    // Back-to-back frames with one stop bit.
    base_rdy = rdy_count;
    base_idx = rdy_cycs.size();
    applyStimulus(8'h00, 1'b1, BIT_CLK);
    checkOutput("t2_first_data", 32'(data), 32'h00);
    applyStimulus(8'hFF, 1'b1, BIT_CLK);
    checkOutput("t2_rdy_count", 32'(rdy_count - base_rdy), 32'd2);
    checkOutput("t2_data", 32'(data), 32'hFF);
    if (rdy_cycs.size() >= base_idx + 2)
      checkOutput("t2_spacing", 32'(rdy_cycs[base_idx+1] - rdy_cycs[base_idx]), 32'd1600);
    repeat (10) @(negedge clk);

    // Short low glitch must be rejected at mid start bit.
    base_rdy = rdy_count;
    base_ferr = ferr_count;
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t3_busy_high", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("t3_busy_low", 32'(busy), 32'd0);
    checkOutput("t3_no_rdy", 32'(rdy_count - base_rdy), 32'd0);
    checkOutput("t3_no_ferr", 32'(ferr_count - base_ferr), 32'd0);
    checkOutput("t3_data", 32'(data), 32'hFF);

    // Framing error followed by a held-low break.
    base_rdy = rdy_count;
    base_ferr = ferr_count;
    applyStimulus(8'h3C, 1'b0, BIT_CLK);
    repeat (500) @(negedge clk);
    checkOutput("t4_busy_in_break", 32'(busy), 32'd1);
    checkOutput("t4_ferr_count", 32'(ferr_count - base_ferr), 32'd1);
    checkOutput("t4_no_rdy", 32'(rdy_count - base_rdy), 32'd0);
    checkOutput("t4_data_kept", 32'(data), 32'hFF);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t4_busy_released", 32'(busy), 32'd0);
    repeat (200) @(negedge clk);

    // Reset in the middle of bit 4 of 0x5A aborts the frame.
    base_rdy = rdy_count;
    b = 8'h5A;
    rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd = b[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    checkOutput("t5_busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rxd = 1'b1;
    exp_q.delete();
    last_good = 8'h00;
    checkOutput("t5_busy_after_reset", 32'(busy), 32'd0);
    checkOutput("t5_data_after_reset", 32'(data), 32'h00);
    repeat (400) @(negedge clk);
    checkOutput("t5_no_rdy", 32'(rdy_count - base_rdy), 32'd0);
    checkOutput("t5_still_idle", 32'(busy), 32'd0);
    applyStimulus(8'h81, 1'b1, BIT_CLK);
    checkOutput("t5_clean_data", 32'(data), 32'h81);
    checkOutput("t5_rdy_count", 32'(rdy_count - base_rdy), 32'd1);
    repeat (50) @(negedge clk);

    // Random bytes with slight baud mismatch and random idle gaps.
    base_rdy = rdy_count;
    base_ferr = ferr_count;
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      len = BIT_CLK - 3 + 3 * int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 40));
      applyStimulus(b, 1'b1, len);
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    checkOutput("t6_rdy_count", 32'(rdy_count - base_rdy), 32'd30);
    checkOutput("t6_no_ferr", 32'(ferr_count - base_ferr), 32'd0);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
